seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
Parametrised N-digit multiplexed seven-segment scan controller. It replaces the fixed 4-digit divider chain, cycle counter and decoder path with one synchronous block. Features: programmable prescaler, anti-ghosting dead time, per-digit blank and decimal point, leading-zero suppression, and a tear-free load handshake. It sits between datapath result registers and the board display pins.

Parameters:
DIGITS, 4, number of digits scanned; legal range 2..8
PRESCALE, 50000, clk cycles per digit slot; must be >= DEADTIME+2
DEADTIME, 2, cycles at slot start with all anodes off
CW, $clog2(PRESCALE), prescaler counter width (derived)

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  asynchronous, active-low reset
load  in  1  one-cycle strobe; capture value/dp_in/blank_in
value  in  4*DIGITS  hex nibbles; nibble i (value[4i+3:4i]) drives digit i; digit 0 is rightmost
dp_in  in  DIGITS  decimal point request per digit, active-high
blank_in  in  DIGITS  force digit i blank, active-high
lz_en  in  1  leading-zero suppression enable; sampled live
seg  out  7  segments abc_defg, bit6=a, bit0=g, active-low
dp  out  1  decimal point, active-low
an  out  DIGITS  digit enables, active-low, one-hot-low or all-high
load_ack  out  1  one-cycle pulse when captured data becomes displayed
frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (reset=0, asynchronous): an=all 1, seg=7'h7F, dp=1, load_ack=0, frame_tick=0. Internal state cleared: prescaler=0, digit index=0, shadow regs=0, pending=0.
- Prescaler: counts 0..PRESCALE-1, then wraps to 0. The terminal count (TC) advances the digit index 0,1,..,DIGITS-1,0.
- Frame boundary: TC while index==DIGITS-1. frame_tick pulses in the cycle after that TC.
- Outputs are fully registered. They reflect the new slot starting 1 cycle after TC.
- Dead time: for prescaler values 0..DEADTIME-1, an=all 1, seg=7F, dp=1. Otherwise an[idx]=0 and all other an bits =1.
- Glyphs (active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- Blanking: a blanked digit drives seg=7F and dp=1, but its an bit is still driven low (constant duty cycle).
- A digit is blanked if blank_sh[i]=1, or if lz_en=1 and it is suppressed.
- Suppression rule: digit i is suppressed if every nibble j>=i in the shadow is 0, and i!=0. Digit 0 is never suppressed.
- dp: dp = ~dp_sh[idx] when the digit is not blanked.
- Load handshake:
  - load=1 captures value, dp_in and blank_in into the pending regs and sets pending=1.
  - At the next frame boundary: shadow <= pending regs, pending <= 0, and load_ack pulses in the following cycle, coincident with frame_tick.
  - Load while pending: pending regs overwritten, latest wins; one ack only.
  - Load in the same cycle as a frame-boundary TC: bypass; the data goes directly to shadow at that boundary and is acked.
- The display never shows mixed old/new digits within one frame.
- Reset mid-frame: all of the above is cleared immediately and any pending load is discarded with no ack.

Decomposition:
- Package seg7_pkg: the 16 glyph constants, SEG_BLANK=7'h7F, and a function returning the suppression mask for a given DIGITS.
- One sub-module, hex_to_seg7: combinational nibble-to-glyph decoder, instantiated once on the muxed nibble.
- Prescaler, scan index, handshake and output registers stay in the top module.

Test Plan:
- Bench parameters for all scenarios: DIGITS=4, PRESCALE=4, DEADTIME=1.
- Reset release, no load -> an cycles 1110,1101,1011,0111 with 1 dead cycle (1111) per slot. seg=0000001 on every lit slot; frame_tick every 16 cycles.
- load value=16'h12AF, dp_in=4'b0100 mid-frame -> display unchanged until the boundary. load_ack and frame_tick pulse together. Then digits show F,A,2,1 (0111000,0001000,0010010,1001111), with dp=0 only on the an=1011 slot.
- value=16'h0040, lz_en=1 -> digits 3 and 2 blank (seg=7F, an still low), digit1=4, digit0=0. Toggling lz_en=0 -> 0,0,4,0 shown on the next slots.
- Two loads (16'h1111, then 16'h2222) within one frame -> a single load_ack; 2222 displayed; 1111 never appears.
- load asserted in the TC cycle of digit 3 -> new value shown from the very next slot, with ack in the same cycle as frame_tick.
- reset asserted while pending=1 -> outputs immediately at reset values; after release, no load_ack and display=0000.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - glyph constants and leading-zero suppression helper for the seven-segment scanner
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [6:0] GLYPH_0 = 7'b0000001;
   localparam logic [6:0] GLYPH_1 = 7'b1001111;
   localparam logic [6:0] GLYPH_2 = 7'b0010010;
   localparam logic [6:0] GLYPH_3 = 7'b0000110;
   localparam logic [6:0] GLYPH_4 = 7'b1001100;
   localparam logic [6:0] GLYPH_5 = 7'b0100100;
   localparam logic [6:0] GLYPH_6 = 7'b0100000;
   localparam logic [6:0] GLYPH_7 = 7'b0001111;
   localparam logic [6:0] GLYPH_8 = 7'b0000000;
   localparam logic [6:0] GLYPH_9 = 7'b0000100;
   localparam logic [6:0] GLYPH_A = 7'b0001000;
   localparam logic [6:0] GLYPH_B = 7'b1100000;
   localparam logic [6:0] GLYPH_C = 7'b0110001;
   localparam logic [6:0] GLYPH_D = 7'b1000010;
   localparam logic [6:0] GLYPH_E = 7'b0110000;
   localparam logic [6:0] GLYPH_F = 7'b0111000;

   // Bit i set when nibble i and every nibble above it are zero; digit 0 never suppressed.
   function automatic logic [7:0] suppress_mask(input logic [31:0] nibbles, input int digits);
      logic [7:0] mask;
      logic       all_zero;
      mask     = '0;
      all_zero = 1'b1;
      for (int i = 7; i >= 1; i--) begin
         if (i < digits) begin
            all_zero = all_zero & (nibbles[4*i +: 4] == 4'h0);
            mask[i]  = all_zero;
         end
      end
      return mask;
   endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex nibble to active-low seven-segment glyph decoder
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] glyph
);

   always_comb begin
      glyph = SEG_BLANK;
      case (nibble)
         4'h0: glyph = GLYPH_0;
         4'h1: glyph = GLYPH_1;
         4'h2: glyph = GLYPH_2;
         4'h3: glyph = GLYPH_3;
         4'h4: glyph = GLYPH_4;
         4'h5: glyph = GLYPH_5;
         4'h6: glyph = GLYPH_6;
         4'h7: glyph = GLYPH_7;
         4'h8: glyph = GLYPH_8;
         4'h9: glyph = GLYPH_9;
         4'hA: glyph = GLYPH_A;
         4'hB: glyph = GLYPH_B;
         4'hC: glyph = GLYPH_C;
         4'hD: glyph = GLYPH_D;
         4'hE: glyph = GLYPH_E;
         4'hF: glyph = GLYPH_F;
         default: glyph = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - N-digit multiplexed seven-segment scan controller with frame-aligned load handshake
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 50000,
   parameter int DEADTIME = 2,
   parameter int CW       = $clog2(PRESCALE)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     blank_in,
   input  logic                  lz_en,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     an,
   output logic                  load_ack,
   output logic                  frame_tick
);

   localparam int IW = $clog2(DIGITS);

   logic [CW-1:0]          cnt, cnt_n;
   logic [IW-1:0]          idx, idx_n;
   logic                   tc, boundary, dead, blanked, pending;
   logic [4*DIGITS-1:0]    pend_val, sh_val, sh_val_n;
   logic [DIGITS-1:0]      pend_dp, pend_blank, sh_dp, sh_blank, sh_dp_n, sh_blank_n, supp;
   logic [3:0]             nibble;
   logic [6:0]             glyph;

   assign tc       = (cnt == CW'(PRESCALE - 1));
   assign boundary = tc && (idx == IW'(DIGITS - 1));
   assign cnt_n    = tc ? '0 : cnt + CW'(1);

   always_comb begin
      idx_n = idx;
      if (tc) idx_n = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
   end

   // Shadow only changes at a frame boundary; a load in that same cycle bypasses the pending regs.
   always_comb begin
      sh_val_n   = sh_val;
      sh_dp_n    = sh_dp;
      sh_blank_n = sh_blank;
      if (boundary && load) begin
         sh_val_n   = value;
         sh_dp_n    = dp_in;
         sh_blank_n = blank_in;
      end else if (boundary && pending) begin
         sh_val_n   = pend_val;
         sh_dp_n    = pend_dp;
         sh_blank_n = pend_blank;
      end
   end

   always_comb begin
      nibble = 4'h0;
      for (int i = 0; i < DIGITS; i++)
         if (idx_n == IW'(i)) nibble = sh_val_n[4*i +: 4];
   end

   hex_to_seg7 u_dec (.nibble(nibble), .glyph(glyph));

   assign supp    = DIGITS'(suppress_mask(32'(sh_val_n), DIGITS));
   assign dead    = (cnt_n < CW'(DEADTIME));
   assign blanked = sh_blank_n[idx_n] | (lz_en & supp[idx_n]);

   // Outputs are computed from next-state values so they track the slot the counter is entering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt        <= '0;
         idx        <= '0;
         pending    <= 1'b0;
         pend_val   <= '0;
         pend_dp    <= '0;
         pend_blank <= '0;
         sh_val     <= '0;
         sh_dp      <= '0;
         sh_blank   <= '0;
         an         <= '1;
         seg        <= SEG_BLANK;
         dp         <= 1'b1;
         load_ack   <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         cnt      <= cnt_n;
         idx      <= idx_n;
         sh_val   <= sh_val_n;
         sh_dp    <= sh_dp_n;
         sh_blank <= sh_blank_n;
         if (load) begin
            pend_val   <= value;
            pend_dp    <= dp_in;
            pend_blank <= blank_in;
         end
         if (boundary)  pending <= 1'b0;
         else if (load) pending <= 1'b1;
         frame_tick <= boundary;
         load_ack   <= boundary && (load || pending);
         an         <= dead ? '1 : ~(DIGITS'(1) << idx_n);
         seg        <= (dead || blanked) ? SEG_BLANK : glyph;
         dp         <= (dead || blanked) ? 1'b1 : ~sh_dp_n[idx_n];
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - scoreboard bench for seg7_scan_ctrl (DIGITS=4, PRESCALE=4, DEADTIME=1)
module tb_seg7_scan_ctrl;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } slot_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        load;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic [3:0]  blank_in;
   logic        lz_en;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        load_ack;
   logic        frame_tick;

   int    checks    = 0;
   int    failures  = 0;
   int    ack_count = 0;
   slot_t exp_q[$];

   logic [6:0] glyph_tab [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   seg7_scan_ctrl #(.DIGITS(4), .PRESCALE(4), .DEADTIME(1)) dut (
      .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
      .blank_in(blank_in), .lz_en(lz_en), .seg(seg), .dp(dp), .an(an),
      .load_ack(load_ack), .frame_tick(frame_tick));

   always #5 clk = ~clk;

   always @(posedge clk) if (load_ack === 1'b1) ack_count++;

   task automatic cycle(input int n);
      repeat (n) begin
         @(negedge clk);
         load = 1'b0;
      end
   endtask

   task automatic wait_tick(input string tag);
      int i = 0;
      do begin
         @(negedge clk);
         load = 1'b0;
         i++;
      end while (frame_tick !== 1'b1 && i < 40);
      checks++;
      if (frame_tick !== 1'b1) begin
         failures++;
         $display("FAIL %s wait_tick: frame_tick=%b after %0d cycles, required 1", tag, frame_tick, i);
      end
   endtask

   task automatic push_frame(input logic [15:0] v, input logic [3:0] dpv, input logic [3:0] blank);
      slot_t s;
      for (int d = 0; d < 4; d++) begin
         s.an  = ~(4'b0001 << d);
         s.seg = blank[d] ? 7'h7F : glyph_tab[v[4*d +: 4]];
         s.dp  = blank[d] ? 1'b1 : ~dpv[d];
         exp_q.push_back(s);
      end
   endtask

   task automatic drain(input string tag);
      logic [3:0] prev = 4'hF;
      int         n    = 0;
      slot_t      e;
      while (exp_q.size() > 0 && n < 100) begin
         @(negedge clk);
         load = 1'b0;
         n++;
         if (load_ack === 1'b1) begin
            checks++;
            if (frame_tick !== 1'b1) begin
               failures++;
               $display("FAIL %s ack_with_tick: frame_tick=%b, required 1", tag, frame_tick);
            end
         end
         if (prev === 4'hF && an !== 4'hF) begin
            e = exp_q.pop_front();
            checks++;
            if ({an, seg, dp} !== {e.an, e.seg, e.dp}) begin
               failures++;
               $display("FAIL %s slot: an=%b seg=%b dp=%b, required an=%b seg=%b dp=%b",
                        tag, an, seg, dp, e.an, e.seg, e.dp);
            end
         end
         prev = an;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s drain: %0d slots never shown, required 0", tag, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      int n = 0;
      reset = 1'b0; load = 1'b0; value = '0; dp_in = '0; blank_in = '0; lz_en = 1'b0;
      cycle(3);
      checks++;
      if ({an, seg, dp, load_ack, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_state: an=%b seg=%b dp=%b ack=%b tick=%b, required 1111 1111111 1 0 0",
                  an, seg, dp, load_ack, frame_tick);
      end
      reset = 1'b1;
      wait_tick("reset");
      do begin
         @(negedge clk);
         n++;
      end while (frame_tick !== 1'b1 && n < 40);
      checks++;
      if (n != 16) begin
         failures++;
         $display("FAIL frame_period: %0d cycles, required 16", n);
      end
   endtask

   task automatic test_idle();
      int dead = 0;
      wait_tick("idle");
      push_frame(16'h0000, 4'b0000, 4'b0000);
      drain("idle");
      wait_tick("idle_dead");
      if (an === 4'hF) dead++;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (an === 4'hF) dead++;
      end
      checks++;
      if (dead != 4) begin
         failures++;
         $display("FAIL dead_time: %0d dark cycles per frame, required 4", dead);
      end
   endtask

   task automatic test_load();
      int ack0;
      wait_tick("load");
      ack0  = ack_count;
      value = 16'h12AF; dp_in = 4'b0100; load = 1'b1;
      push_frame(16'h0000, 4'b0000, 4'b0000);
      push_frame(16'h12AF, 4'b0100, 4'b0000);
      drain("load");
      checks++;
      if (ack_count - ack0 != 1) begin
         failures++;
         $display("FAIL load_ack_count: %0d acks, required 1", ack_count - ack0);
      end
   endtask

   task automatic test_lz();
      wait_tick("lz");
      value = 16'h0040; dp_in = 4'b0000; lz_en = 1'b1; load = 1'b1;
      cycle(1);
      wait_tick("lz_on");
      push_frame(16'h0040, 4'b0000, 4'b1100);
      drain("lz_on");
      wait_tick("lz_off");
      lz_en = 1'b0;
      push_frame(16'h0040, 4'b0000, 4'b0000);
      drain("lz_off");
   endtask

   task automatic test_back_to_back();
      int ack0;
      wait_tick("b2b");
      ack0  = ack_count;
      value = 16'h1111; load = 1'b1;
      cycle(4);
      value = 16'h2222; load = 1'b1;
      cycle(1);
      wait_tick("b2b_frame");
      push_frame(16'h2222, 4'b0000, 4'b0000);
      drain("b2b");
      wait_tick("b2b_after");
      checks++;
      if (ack_count - ack0 != 1) begin
         failures++;
         $display("FAIL b2b_ack_count: %0d acks, required 1", ack_count - ack0);
      end
   endtask

   task automatic test_tc_load();
      wait_tick("tc");
      cycle(15);
      value = 16'h9C6D; dp_in = 4'b1001; load = 1'b1;
      cycle(1);
      checks++;
      if ({frame_tick, load_ack} !== 2'b11) begin
         failures++;
         $display("FAIL tc_bypass_ack: tick=%b ack=%b, required 1 1", frame_tick, load_ack);
      end
      push_frame(16'h9C6D, 4'b1001, 4'b0000);
      drain("tc");
   endtask

   task automatic test_reset_pending();
      int ack0;
      wait_tick("rst_pend");
      value = 16'hFFFF; dp_in = 4'b1111; load = 1'b1;
      cycle(3);
      reset = 1'b0;
      #1;
      checks++;
      if ({an, seg, dp, load_ack, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL async_reset: an=%b seg=%b dp=%b ack=%b tick=%b, required 1111 1111111 1 0 0",
                  an, seg, dp, load_ack, frame_tick);
      end
      cycle(2);
      reset = 1'b1;
      ack0  = ack_count;
      wait_tick("rst_pend_frame");
      push_frame(16'h0000, 4'b0000, 4'b0000);
      drain("rst_pend");
      checks++;
      if (ack_count - ack0 != 0) begin
         failures++;
         $display("FAIL rst_pend_ack: %0d acks, required 0", ack_count - ack0);
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_load();
      test_lz();
      test_back_to_back();
      test_tc_load();
      test_reset_pending();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
